// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEFAULT    = 26;
  localparam int DEF_HALF_DEFAULT = 124999;
  localparam int MAX_CH           = 8;

  // Bits needed to index n items, never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < n) begin
        r = r + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, terminal, pending reprogram value and toggle/tick.
// Optional phase alignment input `sync` exists when CLK_DIV_PHASE_SYNC_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic             sync,
`endif
  output logic             applied,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] term_q, term_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             applied_q, applied_d;
  logic             terminal;
  logic             sync_now;

`ifdef CLK_DIV_PHASE_SYNC_EN
  assign sync_now = sync;
`else
  assign sync_now = 1'b0;
`endif

  assign terminal = (cnt_q == term_q);

  always_comb begin
    cnt_d     = cnt_q;
    term_d    = term_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    applied_d = 1'b0;

    if (sync_now) begin
      // Phase alignment keeps any pending value for a later normal apply.
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (en) begin
      if (terminal) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        if (pend_v_q) begin
          term_d    = pend_q;
          pend_v_d  = 1'b0;
          applied_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pend_v_q) begin
      term_d    = pend_q;
      cnt_d     = '0;
      pend_v_d  = 1'b0;
      applied_d = 1'b1;
    end

    // A write landing on an apply cycle is held for the next apply opportunity.
    if (wr) begin
      pend_d   = val;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      term_q    <= CNT_W'(DEF_HALF);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      term_q    <= term_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      applied_q <= applied_d;
    end
  end

  assign applied = applied_q;
  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable even-ratio clock divider with tick strobes.
// Define CLK_DIV_PHASE_SYNC_EN to add the `sync` phase-alignment input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT,
  parameter int SEL_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
`ifdef CLK_DIV_PHASE_SYNC_EN
  input  logic              sync,
`endif
  output logic              div_ack,
  output logic              div_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  if (NUM_CH < 1 || NUM_CH > MAX_CH || SEL_W < clog2(NUM_CH)) begin : g_bad_cfg
    $error("clk_div_multi: illegal NUM_CH/SEL_W combination");
  end

  // One extra bit so NUM_CH itself is representable when it equals 2**SEL_W.
  localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] applied;
  logic              div_err_q, div_err_d;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign wr_sel[gi] = div_wr && (div_sel == SEL_W'(gi));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[gi]),
      .wr      (wr_sel[gi]),
      .val     (div_val),
`ifdef CLK_DIV_PHASE_SYNC_EN
      .sync    (sync),
`endif
      .applied (applied[gi]),
      .clk_out (clk_out[gi]),
      .tick    (tick[gi])
    );
  end

  always_comb begin
    div_err_d = div_wr && ({1'b0, div_sel} >= NUM_CH_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_err_q <= 1'b0;
    end else begin
      div_err_q <= div_err_d;
    end
  end

  assign div_err = div_err_q;
  // Per-channel applied flags are registered, so the OR is a clean single pulse.
  assign div_ack = |applied;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (NUM_CH=2, DEF_HALF=3).
module tb_clk_div_multi;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 3;
  localparam int SEL_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_val;
  logic              div_ack;
  logic              div_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLK_DIV_PHASE_SYNC_EN
  logic              sync;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_multi #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF),
    .SEL_W    (SEL_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_wr  (div_wr),
    .div_sel (div_sel),
    .div_val (div_val),
`ifdef CLK_DIV_PHASE_SYNC_EN
    .sync    (sync),
`endif
    .div_ack (div_ack),
    .div_err (div_err),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] val);
    div_wr  = 1'b1;
    div_sel = sel;
    div_val = val;
    $display("wr sel=%0d val=%0d at %0t", sel, val, $time);
  endtask

  initial begin
    rst     = 1'b1;
    en      = '0;
    div_wr  = 1'b0;
    div_sel = '0;
    div_val = '0;
`ifdef CLK_DIV_PHASE_SYNC_EN
    sync    = 1'b0;
`endif
    step();
    step();
    check_eq("rst_clk_out", clk_out, 2'b00);
    check_eq("rst_tick", tick, 2'b00);
    check_eq("rst_ack", div_ack, 1'b0);
    check_eq("rst_err", div_err, 1'b0);

    // Default ratio: toggle every 4 cycles, first tick on 4th enabled cycle.
    rst = 1'b0;
    en  = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      step();
      check_eq($sformatf("def_tick_e%0d", k), tick, (k % 4 == 0) ? 2'b11 : 2'b00);
      check_eq($sformatf("def_clk_e%0d", k), clk_out, (k >= 4 && k < 8) ? 2'b11 : 2'b00);
    end

    // Glitch-free reprogram of ch0 mid half-period.
    step();                       // edge 9
    issue_wr(3'd0, 8'd1);
    step();                       // edge 10
    div_wr = 1'b0;
    check_eq("rp_clk0_e10", clk_out[0], 1'b0);
    check_eq("rp_ack_e10", div_ack, 1'b0);
    for (int k = 11; k <= 16; k++) begin
      step();
      check_eq($sformatf("rp_tick0_e%0d", k), tick[0], (k == 12 || k == 14 || k == 16));
      check_eq($sformatf("rp_clk0_e%0d", k), clk_out[0], (k == 12 || k == 13 || k == 16));
      check_eq($sformatf("rp_ack_e%0d", k), div_ack, (k == 12));
      check_eq($sformatf("rp_tick1_e%0d", k), tick[1], (k == 12 || k == 16));
    end

    // Disabled channel freezes, then resumes from the held count.
    step();                       // edge 17
    step();                       // edge 18, ch1 cnt=2
    en = 2'b01;
    for (int k = 19; k <= 23; k++) begin
      step();
      check_eq($sformatf("dis_tick1_e%0d", k), tick[1], 1'b0);
      check_eq($sformatf("dis_clk1_e%0d", k), clk_out[1], 1'b0);
    end
    en = 2'b11;
    step();                       // edge 24
    check_eq("res_tick1_e24", tick[1], 1'b0);
    step();                       // edge 25
    check_eq("res_tick1_e25", tick[1], 1'b1);
    check_eq("res_clk1_e25", clk_out[1], 1'b1);

    // Write to a stopped channel applies the next cycle.
    en = 2'b01;
    issue_wr(3'd1, 8'd2);
    step();                       // edge 26
    div_wr = 1'b0;
    check_eq("stp_ack_e26", div_ack, 1'b0);
    check_eq("stp_err_e26", div_err, 1'b0);
    step();                       // edge 27
    check_eq("stp_ack_e27", div_ack, 1'b1);
    check_eq("stp_clk1_e27", clk_out[1], 1'b1);
    step();                       // edge 28
    check_eq("stp_ack_e28", div_ack, 1'b0);
    en = 2'b11;
    step();
    check_eq("new_tick1_e29", tick[1], 1'b0);
    step();
    check_eq("new_tick1_e30", tick[1], 1'b0);
    step();
    check_eq("new_tick1_e31", tick[1], 1'b1);
    check_eq("new_clk1_e31", clk_out[1], 1'b0);

    // Invalid channel writes.
    issue_wr(3'd5, 8'd0);
    step();                       // edge 32
    div_wr = 1'b0;
    check_eq("err5_err_e32", div_err, 1'b1);
    check_eq("err5_ack_e32", div_ack, 1'b0);
    step();                       // edge 33
    check_eq("err5_err_e33", div_err, 1'b0);
    check_eq("err5_tick1_e33", tick[1], 1'b0);
    issue_wr(3'd2, 8'd0);
    step();                       // edge 34
    div_wr = 1'b0;
    check_eq("err5_tick1_e34", tick[1], 1'b1);
    check_eq("err5_ack_e34", div_ack, 1'b0);
    check_eq("err2_err_e34", div_err, 1'b1);
    for (int k = 35; k <= 39; k++) begin
      step();
      check_eq($sformatf("err_ack_e%0d", k), div_ack, 1'b0);
      check_eq($sformatf("err_err_e%0d", k), div_err, 1'b0);
    end

    // Reset mid-operation discards a pending write.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
    end
    check_eq("mr_clk_pre", clk_out, 2'b11);
    issue_wr(3'd0, 8'd0);
    step();
    div_wr = 1'b0;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mr_clk", clk_out, 2'b00);
    check_eq("mr_tick", tick, 2'b00);
    check_eq("mr_ack", div_ack, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq($sformatf("mr_ack_c%0d", k), div_ack, 1'b0);
      check_eq($sformatf("mr_tick0_c%0d", k), tick[0], (k == 4));
    end

`ifdef CLK_DIV_PHASE_SYNC_EN
    // Phase alignment of channels with term 3 and 5.
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue_wr(3'd1, 8'd5);
    step();
    div_wr = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      step();
    end
    sync = 1'b1;
    step();
    sync = 1'b0;
    check_eq("sy_clk", clk_out, 2'b00);
    check_eq("sy_tick", tick, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq($sformatf("sy_tick0_c%0d", k), tick[0], (k == 4));
      check_eq($sformatf("sy_tick1_c%0d", k), tick[1], (k == 6));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
